led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// Six-LED pattern sequencer: four display modes stepped by a prescaler,
// with mode-advance and run/pause buttons.
module led_sequencer #(
  parameter int WAIT_TIME = 13500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_pause,
  output logic [5:0] led,
  output logic [1:0] mode,
  output logic       running,
  output logic       step
);

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  localparam logic [23:0] LAST = 24'(WAIT_TIME - 1);

  state_t      state;
  state_t      state_next;
  logic [23:0] presc;
  logic [5:0]  pattern;
  logic [5:0]  pat_next;
  logic        dir_left;
  logic        dir_next;
  logic        mode_q;
  logic        pause_q;
  logic        mode_edge;
  logic        pause_edge;
  logic        tick;

  function automatic logic [5:0] init_pat(input logic [1:0] m);
    logic [5:0] p;
    unique case (m)
      2'd0:    p = 6'd0;
      2'd1:    p = 6'd63;
      default: p = 6'd1;
    endcase
    return p;
  endfunction

  assign mode_edge  = btn_mode & ~mode_q;
  assign pause_edge = btn_pause & ~pause_q;

  // A button edge in the wrap cycle swallows the tick
  assign tick = (state == RUN) && (presc == LAST)
             && !mode_edge && !pause_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (pause_edge) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end
  end

  always_comb begin
    running = (state == RUN);
  end

  always_comb begin
    pat_next = pattern;
    dir_next = dir_left;
    unique case (mode)
      2'd0: pat_next = pattern + 6'd1;
      2'd1: pat_next = pattern - 6'd1;
      2'd2: pat_next = {pattern[4:0], pattern[5]};
      2'd3: begin
        pat_next = dir_left ? (pattern << 1) : (pattern >> 1);
        if (pat_next[5]) begin
          dir_next = 1'b0;
        end else if (pat_next[0]) begin
          dir_next = 1'b1;
        end
      end
      default: pat_next = pattern;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= 2'd0;
      pattern  <= 6'd0;
      dir_left <= 1'b1;
      presc    <= 24'd0;
      step     <= 1'b0;
      mode_q   <= 1'b1;
      pause_q  <= 1'b1;
    end else begin
      mode_q  <= btn_mode;
      pause_q <= btn_pause;
      step    <= tick;
      if (mode_edge) begin
        mode     <= mode + 2'd1;
        pattern  <= init_pat(mode + 2'd1);
        dir_left <= 1'b1;
        presc    <= 24'd0;
      end else if (tick) begin
        pattern  <= pat_next;
        dir_left <= dir_next;
        presc    <= 24'd0;
      end else if (state == RUN && !pause_edge) begin
        presc <= presc + 24'd1;
      end
    end
  end

  assign led = ~pattern;

endmodule
